// File: rtl/xor_test_sequencer_pkg.sv
// Shared definitions for the XOR self-test sequencer: state encoding,
// vector count, "no failure" marker and the stimulus/expected tables.
package xor_test_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam int         NUM_VEC  = 7;
  localparam logic [2:0] NO_FAIL  = 3'd7;
  localparam logic [2:0] LAST_VEC = 3'd6;

  // {in1,in2} applied for each vector index
  function automatic logic [1:0] vec_in(input logic [2:0] idx);
    logic [1:0] v;
    v = 2'b00;
    case (idx)
      3'd0: v = 2'b00;
      3'd1: v = 2'b10;
      3'd2: v = 2'b11;
      3'd3: v = 2'b01;
      3'd4: v = 2'b00;
      3'd5: v = 2'b01;
      3'd6: v = 2'b10;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  function automatic logic vec_exp(input logic [2:0] idx);
    logic [1:0] v;
    v = vec_in(idx);
    return v[1] ^ v[0];
  endfunction

endpackage

// File: rtl/xor_test_sequencer_dwell_timer.sv
// Down-counter that times how long each vector is held before sampling.
module xor_test_sequencer_dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] load_val,
  output logic               zero
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/xor_test_sequencer.sv
// Self-test controller for a 2-input XOR unit: walks a fixed truth-table
// pattern, samples the unit after a dwell and reports pass/fail results.
module xor_test_sequencer
  import xor_test_sequencer_pkg::*;
#(
  parameter int DWELL_CYCLES = 10,
  parameter int DWELL_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  input  logic       dut_out,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [2:0] fail_idx,
  output logic [2:0] vec_idx
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

  state_t state;
  logic   tmr_zero;
  logic   mismatch;
  logic   launch;

  xor_test_sequencer_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == S_DRIVE),
    .en       (state == S_WAIT),
    .load_val (DWELL_LOAD),
    .zero     (tmr_zero)
  );

  assign mismatch = dut_out ^ vec_exp(vec_idx);
  // a run begins either from a start request or an automatic restart
  assign launch   = ((state == S_IDLE) && start) || ((state == S_FINISH) && continuous);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dut_in1   <= 1'b0;
      dut_in2   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_idx  <= NO_FAIL;
      vec_idx   <= 3'd0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        state                <= S_DRIVE;
        vec_idx              <= 3'd0;
        {dut_in1, dut_in2}   <= vec_in(3'd0);
        busy                 <= 1'b1;
        pass                 <= 1'b0;
        err_count            <= 3'd0;
        fail_idx             <= NO_FAIL;
      end else begin
        case (state)
          S_IDLE: begin
            busy <= 1'b0;
          end
          S_DRIVE: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (tmr_zero) state <= S_SAMPLE;
          end
          S_SAMPLE: begin
            if (mismatch) begin
              err_count <= err_count + 3'd1;
              if (fail_idx == NO_FAIL) fail_idx <= vec_idx;
            end
            // pass must include the verdict of the vector sampled right now
            if (vec_idx == LAST_VEC) begin
              state <= S_FINISH;
              done  <= 1'b1;
              pass  <= (err_count == 3'd0) && !mismatch;
            end else begin
              state              <= S_DRIVE;
              vec_idx            <= vec_idx + 3'd1;
              {dut_in1, dut_in2} <= vec_in(vec_idx + 3'd1);
            end
          end
          S_FINISH: begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            dut_in1 <= 1'b0;
            dut_in2 <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xor_test_sequencer.sv
// Directed bench for xor_test_sequencer: run-timeline model checked every cycle
// plus literal expectations for each scenario.
module tb_xor_test_sequencer;

  localparam int DW = 10;
  localparam int P  = DW + 2;
  localparam int NV = 7;
  localparam logic [1:0] TV  [NV] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b10};
  localparam logic       EXP [NV] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic dut_out;
  logic dut_in1, dut_in2, busy, done, pass;
  logic [2:0] err_count, fail_idx, vec_idx;
  int fault = 0;

  int ncmp = 0;
  int nbad = 0;
  int cyc  = 0;
  int ndone = 0;

  always #5 clk = ~clk;

  // unit under control: ideal XOR, stuck-at-0, or OR fault
  assign dut_out = (fault == 1) ? 1'b0 :
                   (fault == 2) ? (dut_in1 | dut_in2) : (dut_in1 ^ dut_in2);

  xor_test_sequencer #(.DWELL_CYCLES(DW), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .dut_out(dut_out), .dut_in1(dut_in1), .dut_in2(dut_in2), .busy(busy),
    .done(done), .pass(pass), .err_count(err_count), .fail_idx(fail_idx),
    .vec_idx(vec_idx)
  );

  // model: outputs as a function of edges elapsed since the run began
  bit         m_act = 0;
  int         m_s = 0;
  int         m_err = 0;
  logic [2:0] m_fail = 3'd7;
  logic       m_pass = 0, m_done = 0, m_busy = 0;
  logic [2:0] m_vec = 0;
  logic [1:0] m_in = 0;

  always @(posedge clk) begin
    int k;
    int j;
    cyc++;
    if (!rst_n) begin
      m_act = 0; m_err = 0; m_fail = 3'd7; m_pass = 0; m_done = 0;
      m_busy = 0; m_vec = 0; m_in = 0;
    end else begin
      m_done = 0;
      if (!m_act) begin
        if (start) begin
          m_act = 1; m_s = cyc; m_err = 0; m_fail = 3'd7; m_pass = 0;
        end
      end else begin
        k = cyc - m_s;
        if (k >= P && k <= NV * P && (k % P) == 0) begin
          j = k / P - 1;
          if (dut_out !== EXP[j]) begin
            m_err++;
            if (m_fail == 3'd7) m_fail = 3'(j);
          end
        end
        if (k == NV * P + 1) begin
          if (continuous) begin
            m_s = cyc; m_err = 0; m_fail = 3'd7; m_pass = 0;
          end else begin
            m_act = 0;
          end
        end
      end
      k = cyc - m_s;
      if (m_act) begin
        m_busy = 1;
        if (k < NV * P) begin
          m_vec = 3'(k / P);
          m_in  = TV[k / P];
        end else begin
          m_done = 1;
          m_pass = (m_err == 0);
        end
      end else begin
        m_busy = 0;
        m_in   = 2'b00;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic [13:0] act;
      logic [13:0] expv;
      act  = {busy, done, pass, err_count, fail_idx, vec_idx, dut_in1, dut_in2};
      expv = {m_busy, m_done, m_pass, 3'(m_err), m_fail, m_vec, m_in};
      ncmp++;
      if (act !== expv) begin
        nbad++;
        $display("FAIL cycle %0d outputs {busy,done,pass,err,fail,vec,in1,in2}: got %b expected %b",
                 cyc, act, expv);
      end
      if (done === 1'b1) ndone++;
    end
  end

  task automatic check(input string nm, input int act, input int expv);
    ncmp++;
    if (act != expv) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // advance to the negedge just before edge number 'e'
  task automatic until_edge(input int e);
    while (cyc + 1 < e) @(negedge clk);
  endtask

  // returns the edge number at which done is first seen, -1 on timeout
  task automatic wait_done(input int max, output int e);
    e = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        e = cyc + 1;
        break;
      end
    end
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc + 1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int s, d, d2, d3, nd0;
    tick(3);
    check("reset busy", int'(busy), 0);
    check("reset fail_idx", int'(fail_idx), 7);
    check("reset dut_in", int'({dut_in1, dut_in2}), 0);
    rst_n = 1'b1;
    tick(2);

    // ideal unit
    fault = 0;
    pulse_start(s);
    wait_done(200, d);
    check("t1 done edge", d - s, 85);
    check("t1 pass", int'(pass), 1);
    check("t1 err_count", int'(err_count), 0);
    check("t1 fail_idx", int'(fail_idx), 7);
    tick(4);
    check("t1 pass held in idle", int'(pass), 1);

    // stuck-at-0
    fault = 1;
    pulse_start(s);
    wait_done(200, d);
    check("t2 done edge", d - s, 85);
    check("t2 err_count", int'(err_count), 4);
    check("t2 fail_idx", int'(fail_idx), 1);
    check("t2 pass", int'(pass), 0);
    tick(4);

    // OR fault
    fault = 2;
    pulse_start(s);
    wait_done(200, d);
    check("t3 err_count", int'(err_count), 1);
    check("t3 fail_idx", int'(fail_idx), 2);
    check("t3 pass", int'(pass), 0);
    tick(4);

    // start held then re-pulsed while busy
    fault = 0;
    nd0 = ndone;
    start = 1'b1;
    s = cyc + 1;
    tick(20);
    start = 1'b0;
    until_edge(s + 30);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(200, d);
    check("t4 done edge", d - s, 85);
    tick(60);
    check("t4 done count", ndone - nd0, 1);

    // continuous mode
    continuous = 1'b1;
    pulse_start(s);
    wait_done(200, d);
    check("t5 done1 edge", d - s, 85);
    wait_done(200, d2);
    check("t5 done2 edge", d2 - s, 170);
    until_edge(s + 200);
    continuous = 1'b0;
    wait_done(200, d3);
    check("t5 done3 edge", d3 - s, 255);
    tick(3);
    check("t5 idle busy", int'(busy), 0);

    // mid-run reset
    fault = 1;
    pulse_start(s);
    until_edge(s + 40);
    check("t6 err before reset", int'(err_count), 1);
    rst_n = 1'b0;
    tick(1);
    check("t6 busy", int'(busy), 0);
    check("t6 dut_in", int'({dut_in1, dut_in2}), 0);
    check("t6 err_count", int'(err_count), 0);
    check("t6 fail_idx", int'(fail_idx), 7);
    rst_n = 1'b1;
    fault = 0;
    tick(1);
    pulse_start(s);
    wait_done(200, d);
    check("t6 fresh done edge", d - s, 85);
    check("t6 fresh pass", int'(pass), 1);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
